// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC stage that sits in front of the instruction memory.
// It handles sequential, branch, J/JAL and JR redirects, the R31 link write, and a sticky halt.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_off,
  input  logic        jump_en,
  input  logic [25:0] jump_idx,
  input  logic        jal,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        halted,
  output logic        misaligned,
  output logic [31:0] inst_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // One byte past the last legal word. The extra bit keeps large MEM_WORDS values from wrapping.
  localparam logic [32:0] PC_LIMIT = 33'(4 * MEM_WORDS);

  state_t      state, state_d;
  logic [31:0] pc_d, count_d, next_pc, branch_target;
  logic        halted_d, misaligned_d;
  logic        jr_misaligned, out_of_range;

  assign pc_plus4      = pc + 32'd4;
  assign link_data     = pc_plus4;
  assign fetch_valid   = (state == RUN);
  assign link_we       = fetch_valid & ~stall & jump_en & jal & ~jr_en;
  assign branch_target = pc_plus4 + {{14{branch_off[15]}}, branch_off, 2'b00};

  always_comb begin
    if (jr_en)             next_pc = jr_target;
    else if (jump_en)      next_pc = {pc_plus4[31:28], jump_idx, 2'b00};
    else if (branch_taken) next_pc = branch_target;
    else                   next_pc = pc_plus4;
  end

  assign jr_misaligned = jr_en && (jr_target[1:0] != 2'b00);
  assign out_of_range  = ({1'b0, next_pc} >= PC_LIMIT);

  always_comb begin
    // NOTE: every combinational output gets a default first so that no path infers a latch.
    state_d      = state;
    pc_d         = pc;
    count_d      = inst_count;
    halted_d     = halted;
    misaligned_d = misaligned;
    unique case (state)
      BOOT: state_d = RUN;
      RUN: begin
        if (!stall) begin
          if (jr_misaligned) begin
            state_d      = HALT;
            halted_d     = 1'b1;
            misaligned_d = 1'b1;
          end else if (out_of_range) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            pc_d    = next_pc;
            count_d = inst_count + 32'd1;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      inst_count <= 32'd0;
      halted     <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      inst_count <= count_d;
      halted     <= halted_d;
      misaligned <= misaligned_d;
    end
  end

endmodule
